// File: rtl/multicycle_pkg.sv
// Shared encodings for the multi-cycle CPU control path:
// opcodes, controller states and datapath select values.
package multicycle_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_BLTZ  = 6'd1;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLE   = 6'd6;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_SLTIU = 6'd9;
  localparam logic [5:0] OP_SLTI  = 6'd10;
  localparam logic [5:0] OP_ORI   = 6'd13;
  localparam logic [5:0] OP_LUI   = 6'd15;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_RWB,
    S_EXEC_I,
    S_IWB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_RTYPE = 3'b010,
    ALU_SLTI  = 3'b100,
    ALU_LUI   = 3'b101,
    ALU_ORI   = 3'b110,
    ALU_SLTIU = 3'b111
  } alu_op_t;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] BR_EQ  = 2'd0;
  localparam logic [1:0] BR_NE  = 2'd1;
  localparam logic [1:0] BR_LE  = 2'd2;
  localparam logic [1:0] BR_LTZ = 2'd3;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

  function automatic alu_op_t imm_alu_op(
    input logic [5:0] op
  );
    unique case (op)
      OP_SLTIU: imm_alu_op = ALU_SLTIU;
      OP_SLTI:  imm_alu_op = ALU_SLTI;
      OP_ORI:   imm_alu_op = ALU_ORI;
      OP_LUI:   imm_alu_op = ALU_LUI;
      default:  imm_alu_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic [1:0] br_type(
    input logic [5:0] op
  );
    unique case (op)
      OP_BNE:  br_type = BR_NE;
      OP_BLE:  br_type = BR_LE;
      OP_BLTZ: br_type = BR_LTZ;
      default: br_type = BR_EQ;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags the last
// permitted wait cycle so the controller can trap.
module mem_wait_timer #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign timeout = (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main controller of the multi-cycle datapath: sequences
// each instruction and drives every mux, enable and ALU op.
module multicycle_ctrl_fsm
  import multicycle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] instr_op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic [1:0] BranchType_o,
  output logic [1:0] PCSource_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic [1:0] MemtoReg_o,
  output logic       RegDst_o,
  output logic       RegWrite_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic [2:0] ALU_op_o,
  output logic       retire_o,
  output logic       trap_o,
  output logic [1:0] trap_code_o
);

  state_t     state_q, state_d;
  logic [1:0] code_q, code_d;
  logic       in_wait, timeout, expire;
  logic       is_r, is_mem, is_imm, is_br, is_j;

  assign is_r   = (instr_op_i == OP_RTYPE);
  assign is_mem = instr_op_i inside {OP_LW, OP_SW};
  assign is_imm = instr_op_i inside
    {OP_ADDI, OP_SLTIU, OP_SLTI, OP_ORI, OP_LUI};
  assign is_br  = instr_op_i inside
    {OP_BEQ, OP_BNE, OP_BLE, OP_BLTZ};
  assign is_j   = (instr_op_i == OP_J);

  assign in_wait = state_q inside
    {S_FETCH, S_MEMRD, S_MEMWR};
  // Ready in the same cycle as the timeout still wins.
  assign expire = in_wait & ~mem_ready_i & timeout;

  mem_wait_timer #(
    .CNT_W (CNT_W),
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk_i),
    .rst_n   (rst_i),
    .clr     (state_d != state_q),
    .en      (in_wait & ~mem_ready_i),
    .timeout (timeout)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      code_q  <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready_i) begin
          unique case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_MEMWB;
            default: state_d = S_FETCH;
          endcase
        end else if (expire) begin
          state_d = S_TRAP;
          code_d  = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          is_r:    state_d = S_EXEC_R;
          is_mem:  state_d = S_MEMADR;
          is_imm:  state_d = S_EXEC_I;
          is_br:   state_d = S_BRANCH;
          is_j:    state_d = S_JUMP;
          default: begin
            state_d = S_TRAP;
            code_d  = TRAP_ILLEGAL;
          end
        endcase
      end
      S_MEMADR: state_d = (instr_op_i == OP_LW)
                        ? S_MEMRD : S_MEMWR;
      S_EXEC_R: state_d = S_RWB;
      S_EXEC_I: state_d = S_IWB;
      S_RWB, S_IWB, S_MEMWB,
      S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    BranchType_o  = BR_EQ;
    PCSource_o    = PCS_ALU;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemtoReg_o    = 2'd0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = SRCB_RT;
    ALU_op_o      = ALU_ADD;
    retire_o      = 1'b0;
    trap_o        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = SRCB_FOUR;
        IRWrite_o = mem_ready_i;
        PCWrite_o = mem_ready_i;
      end
      S_DECODE: ALUSrcB_o = SRCB_IMM_SH;
      S_EXEC_R: begin
        ALUSrcA_o = 1'b1;
        ALU_op_o  = ALU_RTYPE;
      end
      S_RWB: begin
        RegDst_o   = 1'b1;
        RegWrite_o = 1'b1;
        retire_o   = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
        ALU_op_o  = imm_alu_op(instr_op_i);
      end
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = SRCB_IMM;
      end
      S_IWB: begin
        RegWrite_o = 1'b1;
        retire_o   = 1'b1;
      end
      S_MEMRD: begin
        IorD_o    = 1'b1;
        MemRead_o = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg_o = 2'd1;
        RegWrite_o = 1'b1;
        retire_o   = 1'b1;
      end
      S_MEMWR: begin
        IorD_o     = 1'b1;
        MemWrite_o = 1'b1;
        retire_o   = mem_ready_i;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALU_op_o      = ALU_SUB;
        PCWriteCond_o = 1'b1;
        PCSource_o    = PCS_ALUOUT;
        BranchType_o  = br_type(instr_op_i);
        retire_o      = 1'b1;
      end
      S_JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = PCS_JUMP;
        retire_o   = 1'b1;
      end
      S_TRAP:  trap_o = 1'b1;
      default: ;
    endcase
  end

  assign trap_code_o = code_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: per-cycle expected
// control words queued at drive time, checked mid-cycle.
module tb_multicycle_ctrl_fsm;

  typedef struct packed {
    logic       pcw;
    logic       pcwc;
    logic [1:0] bt;
    logic [1:0] pcs;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic [1:0] m2r;
    logic       rd;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       ret;
    logic       trap;
    logic [1:0] tcode;
  } outs_t;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [5:0] instr_op_i = '0;
  logic       mem_ready_i = 1'b0;
  logic       PCWrite_o, PCWriteCond_o;
  logic [1:0] BranchType_o, PCSource_o;
  logic       IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic [1:0] MemtoReg_o;
  logic       RegDst_o, RegWrite_o, ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ALU_op_o;
  logic       retire_o, trap_o;
  logic [1:0] trap_code_o;
  outs_t      obs;

  outs_t exp_q[$];
  string tag_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  multicycle_ctrl_fsm #(
    .MEM_TIMEOUT (16),
    .CNT_W       (8)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .instr_op_i    (instr_op_i),
    .mem_ready_i   (mem_ready_i),
    .PCWrite_o     (PCWrite_o),
    .PCWriteCond_o (PCWriteCond_o),
    .BranchType_o  (BranchType_o),
    .PCSource_o    (PCSource_o),
    .IorD_o        (IorD_o),
    .MemRead_o     (MemRead_o),
    .MemWrite_o    (MemWrite_o),
    .IRWrite_o     (IRWrite_o),
    .MemtoReg_o    (MemtoReg_o),
    .RegDst_o      (RegDst_o),
    .RegWrite_o    (RegWrite_o),
    .ALUSrcA_o     (ALUSrcA_o),
    .ALUSrcB_o     (ALUSrcB_o),
    .ALU_op_o      (ALU_op_o),
    .retire_o      (retire_o),
    .trap_o        (trap_o),
    .trap_code_o   (trap_code_o)
  );

  assign obs = {PCWrite_o, PCWriteCond_o, BranchType_o,
                PCSource_o, IorD_o, MemRead_o, MemWrite_o,
                IRWrite_o, MemtoReg_o, RegDst_o, RegWrite_o,
                ALUSrcA_o, ALUSrcB_o, ALU_op_o, retire_o,
                trap_o, trap_code_o};

  always #5 clk_i = ~clk_i;

  function automatic outs_t e_zero();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t e_fetch(input bit r);
    outs_t o = '0;
    o.mr = 1'b1; o.asb = 2'd1;
    o.pcw = r; o.irw = r;
    return o;
  endfunction

  function automatic outs_t e_decode();
    outs_t o = '0;
    o.asb = 2'd3;
    return o;
  endfunction

  function automatic outs_t e_exec_r();
    outs_t o = '0;
    o.asa = 1'b1; o.aop = 3'b010;
    return o;
  endfunction

  function automatic outs_t e_rwb();
    outs_t o = '0;
    o.rd = 1'b1; o.rw = 1'b1; o.ret = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_exec_i(input logic [2:0] a);
    outs_t o = '0;
    o.asa = 1'b1; o.asb = 2'd2; o.aop = a;
    return o;
  endfunction

  function automatic outs_t e_iwb();
    outs_t o = '0;
    o.rw = 1'b1; o.ret = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_memrd();
    outs_t o = '0;
    o.iord = 1'b1; o.mr = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_memwb();
    outs_t o = '0;
    o.m2r = 2'd1; o.rw = 1'b1; o.ret = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_memwr(input bit r);
    outs_t o = '0;
    o.iord = 1'b1; o.mw = 1'b1; o.ret = r;
    return o;
  endfunction

  function automatic outs_t e_branch(input logic [1:0] b);
    outs_t o = '0;
    o.asa = 1'b1; o.aop = 3'b001; o.pcwc = 1'b1;
    o.pcs = 2'd1; o.bt = b; o.ret = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_jump();
    outs_t o = '0;
    o.pcw = 1'b1; o.pcs = 2'd2; o.ret = 1'b1;
    return o;
  endfunction

  function automatic outs_t e_trap(input logic [1:0] c);
    outs_t o = '0;
    o.trap = 1'b1; o.tcode = c;
    return o;
  endfunction

  task automatic push(input outs_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic sample();
    outs_t e;
    string t;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL empty_queue obs=%h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s obs=%h exp=%h", t, obs, e);
      end
    end
  endtask

  task automatic cyc(input logic [5:0] op, input bit r,
                     input outs_t e, input string t);
    instr_op_i  = op;
    mem_ready_i = r;
    push(e, t);
    @(negedge clk_i);
    sample();
    @(posedge clk_i);
    #1;
  endtask

  task automatic reset_seq();
    rst_i = 1'b0;
    push(e_zero(), "reset_async");
    #1;
    sample();
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cyc(6'd0, 1'b1, e_zero(), "idle");
  endtask

  logic [5:0] iops [5] = '{6'd8, 6'd9, 6'd10, 6'd13, 6'd15};
  logic [2:0] iaop [5] = '{3'b000, 3'b111, 3'b100,
                           3'b110, 3'b101};
  logic [5:0] bops [4] = '{6'd4, 6'd5, 6'd6, 6'd1};

  initial begin
    #3;
    reset_seq();
    cyc(6'd0, 1'b1, e_fetch(1), "r_fetch");
    cyc(6'd0, 1'b1, e_decode(), "r_decode");
    cyc(6'd0, 1'b1, e_exec_r(), "r_exec");
    cyc(6'd0, 1'b1, e_rwb(), "r_wb");

    cyc(6'd35, 1'b1, e_fetch(1), "lw_fetch");
    cyc(6'd35, 1'b1, e_decode(), "lw_decode");
    cyc(6'd35, 1'b1, e_exec_i(3'b000), "lw_memadr");
    for (int i = 0; i < 3; i++)
      cyc(6'd35, 1'b0, e_memrd(), "lw_memrd_wait");
    cyc(6'd35, 1'b1, e_memrd(), "lw_memrd_rdy");
    cyc(6'd35, 1'b0, e_memwb(), "lw_memwb");

    cyc(6'd5, 1'b0, e_fetch(0), "fetch_wait");
    cyc(6'd5, 1'b0, e_fetch(0), "fetch_wait");
    cyc(6'd5, 1'b1, e_fetch(1), "bne_fetch");
    cyc(6'd5, 1'b1, e_decode(), "bne_decode");
    cyc(6'd5, 1'b1, e_branch(2'd1), "bne_branch");

    cyc(6'd2, 1'b1, e_fetch(1), "j_fetch");
    cyc(6'd2, 1'b1, e_decode(), "j_decode");
    cyc(6'd2, 1'b1, e_jump(), "j_jump");

    for (int i = 0; i < 5; i++) begin
      cyc(iops[i], 1'b1, e_fetch(1), "i_fetch");
      cyc(iops[i], 1'b1, e_decode(), "i_decode");
      cyc(iops[i], 1'b1, e_exec_i(iaop[i]), "i_exec");
      cyc(iops[i], 1'b1, e_iwb(), "i_wb");
    end

    for (int i = 0; i < 4; i++) begin
      cyc(bops[i], 1'b1, e_fetch(1), "br_fetch");
      cyc(bops[i], 1'b1, e_decode(), "br_decode");
      cyc(bops[i], 1'b1, e_branch(2'(i)), "br_branch");
    end

    cyc(6'd43, 1'b1, e_fetch(1), "sw_fetch");
    cyc(6'd43, 1'b1, e_decode(), "sw_decode");
    cyc(6'd43, 1'b1, e_exec_i(3'b000), "sw_memadr");
    for (int i = 0; i < 16; i++)
      cyc(6'd43, 1'b0, e_memwr(0), "sw_timeout_wait");
    for (int i = 0; i < 4; i++)
      cyc(6'($urandom_range(0, 63)),
          1'($urandom_range(0, 1)),
          e_trap(2'd2), "trap_timeout");
    reset_seq();

    cyc(6'd43, 1'b1, e_fetch(1), "sw2_fetch");
    cyc(6'd43, 1'b1, e_decode(), "sw2_decode");
    cyc(6'd43, 1'b1, e_exec_i(3'b000), "sw2_memadr");
    for (int i = 0; i < 15; i++)
      cyc(6'd43, 1'b0, e_memwr(0), "sw2_wait");
    cyc(6'd43, 1'b1, e_memwr(1), "sw2_rdy_last");
    cyc(6'd63, 1'b1, e_fetch(1), "ill_fetch");
    cyc(6'd63, 1'b1, e_decode(), "ill_decode");
    for (int i = 0; i < 21; i++)
      cyc(6'($urandom_range(0, 63)),
          1'($urandom_range(0, 1)),
          e_trap(2'd1), "trap_illegal");
    reset_seq();

    cyc(6'd43, 1'b1, e_fetch(1), "sw3_fetch");
    cyc(6'd43, 1'b1, e_decode(), "sw3_decode");
    cyc(6'd43, 1'b1, e_exec_i(3'b000), "sw3_memadr");
    cyc(6'd43, 1'b0, e_memwr(0), "sw3_wait");
    mem_ready_i = 1'b0;
    push(e_memwr(0), "sw3_pre_abort");
    #1;
    sample();
    reset_seq();
    cyc(6'd0, 1'b1, e_fetch(1), "restart_fetch");
    cyc(6'd0, 1'b1, e_decode(), "restart_decode");

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL leftover_expect n=%0d req=0",
             exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
